anu_mem_arbiter: RTL
====================

# anu_mem_arbiter

Shares a single-port memory bus between the core's instruction-fetch port and its load/store port, so the RV32 core runs from one unified memory. A four-state FSM grants the bus, issues byte enables and lane-replicated write data, waits for a bus acknowledge, and raises `stall` to the core until every outstanding request has completed. Data accesses take priority over fetches, because a data access belongs to the instruction currently executing.

## Interface
- `TIMEOUT`, default 255: bus-ack watchdog limit in cycles; used only when `ARB_TIMEOUT_EN` is defined.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request; level, held until `if_valid`.
- `if_addr` in 32: fetch address; word aligned.
- `if_rdata` out 32: fetched instruction; holds its value until the next fetch capture.
- `if_valid` out 1: one-cycle completion pulse for a fetch.
- `d_rd` in 1: load request (always a word read); level.
- `d_mode` in 2: store request. 00 none, 01 byte, 10 half, 11 word; level.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data; the low bits carry the payload.
- `d_rdata` out 32: load data; holds its value until the next capture.
- `d_valid` out 1: one-cycle completion pulse for a data access.
- `err` out 1: one-cycle pulse on a misaligned access or a timeout.
- `stall` out 1: freeze the core's PC and writeback.
- `m_req` out 1: bus request.
- `m_we` out 1: bus write.
- `m_be` out 4: bus byte enables.
- `m_addr` out 32: bus address, with bits [1:0] forced to 0.
- `m_wdata` out 32: bus write data.
- `m_rdata` in 32: bus read data.
- `m_ack` in 1: bus acknowledge; sampled at posedge while `m_req`=1.

## Operation
- The data request is `d_req = d_rd | (d_mode != 0)`. If `d_rd` and a store mode are both set, the store wins.
- States: IDLE, FETCH, DATA, RESP.
- IDLE:
  - If `d_req`, go to DATA.
  - Else if `if_req`, go to FETCH.
  - Else stay in IDLE.
  - The bus address, enables, write flag and write data are registered on the transition.
- FETCH/DATA: `m_req`=1. Stay until `m_ack`=1 is sampled, then go to RESP. At that edge:
  - Reads capture `m_rdata` into `if_rdata` or `d_rdata`.
  - The matching `*_valid` output goes high for the cycle spent in RESP.
- RESP: lasts exactly one cycle, then returns to IDLE. Requests are ignored in RESP. Requesters drop or change their request during the valid cycle.
- Byte enables:
  - Reads: 1111.
  - Byte store: 0001 << addr[1:0].
  - Half store: 1100 if addr[1]=1, else 0011.
  - Word store: 1111.
- Write data:
  - Byte store: `d_wdata[7:0]` replicated to all four lanes.
  - Half store: `d_wdata[15:0]` replicated to both halves.
  - Word store: passed through unchanged.
- Misalignment: a half store with addr[0]=1, or a word store or load with addr[1:0]≠0. No bus cycle is issued. The FSM goes IDLE→RESP with `d_valid`=1 and `err`=1. `d_rdata` is unchanged.
- `stall = (if_req & ~if_valid) | (d_req & ~d_valid)`. This is combinational.
- Reset, including mid-transaction:
  - State goes to IDLE.
  - `m_req`, `m_we`, `if_valid`, `d_valid`, `err` go to 0.
  - `m_be` and `m_addr` go to 0.
  - `if_rdata`, `d_rdata` and `m_wdata` go to 0.
  - A late `m_ack` after reset is ignored, because `m_ack` is only sampled in FETCH or DATA.

## Timing
- A request seen at posedge N drives `m_req`=1 from N+1.
- With `m_ack` high immediately, capture happens at N+2, valid is high during N+2..N+3, and IDLE resumes at N+3.
- Minimum access therefore takes 3 cycles; each bus wait state adds 1 cycle.
- A load plus fetch pending together: DATA completes first. FETCH starts from the IDLE cycle after RESP, giving 6 cycles total at zero wait states.
- `m_*` outputs are registered and stable while `m_req`=1.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit saturating counter runs in FETCH/DATA and is cleared on entry.
  - Reaching `TIMEOUT` aborts the access: `m_req` drops, the FSM goes to RESP, and `err`=1.
  - An aborted fetch returns 32'h0000_0013 (NOP) in `if_rdata`; an aborted load returns 0 in `d_rdata`.
- Undefined: there is no counter, and the FSM waits indefinitely for `m_ack`.

## Test plan
- Fetch only, `if_addr`=0x100, `m_rdata`=0x00500093, ack with 0 waits:
  - `m_req` is high for 1 cycle with `m_be`=1111.
  - `if_valid` pulses 2 cycles after the request edge with `if_rdata`=0x00500093.
  - `stall` is high until `if_valid`.
- Byte store, `d_mode`=01, addr 0x203, wdata 0xAB: `m_be`=1000, `m_wdata`=0xABABABAB, `m_we`=1.
- Half store, `d_mode`=10, addr 0x202, wdata 0x1234: `m_be`=1100, `m_wdata`=0x12341234.
- Half store, `d_mode`=10, addr 0x201: no `m_req`; `err` and `d_valid` pulse together.
- `if_req` and `d_rd` raised in the same cycle, 2 wait states each:
  - The DATA grant occurs first, then FETCH.
  - `stall` stays high until `if_valid`.
- Mid-access reset:
  - Deassert `rst_n` while in DATA: `m_req` drops asynchronously.
  - Then pulse `m_ack` after release with no request pending: the FSM stays in IDLE and no valid is issued.
- With `ARB_TIMEOUT_EN` and `TIMEOUT`=4, never ack a fetch: `err` and `if_valid` are raised with `if_rdata`=0x00000013.

Source files
------------

// File: rtl/anu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : anu_mem_arbiter
// Purpose  : Shares one single-port memory bus between the instruction-fetch
//            port and the load/store port of an RV32 core. Data accesses win
//            over fetches. Generates byte enables, lane-replicated store data,
//            waits for m_ack and stalls the core until its requests complete.
// Options  : ARB_TIMEOUT_EN - when defined, a bus-ack watchdog aborts an
//            access after TIMEOUT cycles (err pulse, NOP / zero read data).
// Revision : 1.0 - initial release
// ============================================================================
module anu_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  // load/store port
  input  logic        d_rd,
  input  logic [1:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  // status to core
  output logic        err,
  output logic        stall,
  // memory bus
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;
  localparam logic [1:0] MODE_WORD = 2'b11;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        err_q, err_d;

  logic        d_store;
  logic        d_req;
  logic        d_misaligned;
  logic [3:0]  d_be;
  logic [31:0] d_lane_wdata;
  logic        timeout_hit;

  // Fetch addresses are word aligned by contract, so their low bits are
  // never examined; the parameter only matters with the watchdog built in.
  logic        unused_ok;
  assign unused_ok = ^{if_addr[1:0], 32'(TIMEOUT)};

  assign d_store = (d_mode != 2'b00);
  assign d_req   = d_rd | d_store;

  // A store mode overrides d_rd, so a load is only checked when no store is set
  always_comb begin
    d_misaligned = 1'b0;
    case (d_mode)
      MODE_BYTE: d_misaligned = 1'b0;
      MODE_HALF: d_misaligned = d_addr[0];
      MODE_WORD: d_misaligned = (d_addr[1:0] != 2'b00);
      default:   d_misaligned = d_rd & (d_addr[1:0] != 2'b00);
    endcase
  end

  // Byte enables and lane-replicated write data for the pending data access
  always_comb begin
    d_be         = 4'b1111;
    d_lane_wdata = d_wdata;
    case (d_mode)
      MODE_BYTE: begin
        d_be         = 4'b0001 << d_addr[1:0];
        d_lane_wdata = {4{d_wdata[7:0]}};
      end
      MODE_HALF: begin
        d_be         = d_addr[1] ? 4'b1100 : 4'b0011;
        d_lane_wdata = {2{d_wdata[15:0]}};
      end
      default: begin
        d_be         = 4'b1111;
        d_lane_wdata = d_wdata;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  logic [7:0] wd_cnt_q;

  // Watchdog: cleared while idle (so it restarts on every grant), saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      wd_cnt_q <= 8'd0;
    end else if ((state_q == ST_FETCH || state_q == ST_DATA) && wd_cnt_q != 8'hFF) begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (({1'b0, wd_cnt_q} + 9'd1) >= {1'b0, TIMEOUT_LIM});
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and bus-register computation for the four-state arbiter
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          if (d_misaligned) begin
            // Rejected without touching the bus
            state_d   = ST_RESP;
            d_valid_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            state_d   = ST_DATA;
            m_req_d   = 1'b1;
            m_we_d    = d_store;
            m_be_d    = d_store ? d_be : 4'b1111;
            m_addr_d  = {d_addr[31:2], 2'b00};
            m_wdata_d = d_lane_wdata;
          end
        end else if (if_req) begin
          state_d  = ST_FETCH;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_be_d   = 4'b1111;
          m_addr_d = {if_addr[31:2], 2'b00};
        end
      end

      ST_FETCH: begin
        if (m_ack) begin
          state_d    = ST_RESP;
          m_req_d    = 1'b0;
          if_rdata_d = m_rdata;
          if_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d    = ST_RESP;
          m_req_d    = 1'b0;
          if_rdata_d = NOP_INSN;
          if_valid_d = 1'b1;
          err_d      = 1'b1;
        end
      end

      ST_DATA: begin
        if (m_ack) begin
          state_d   = ST_RESP;
          m_req_d   = 1'b0;
          d_valid_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = ST_RESP;
          m_req_d   = 1'b0;
          d_valid_d = 1'b1;
          err_d     = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = 32'h0000_0000;
          end
        end
      end

      default: begin
        // Response cycle: valid is visible now, requests are not looked at
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, even mid-access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= 4'b0000;
      m_addr_q   <= 32'h0000_0000;
      m_wdata_q  <= 32'h0000_0000;
      if_rdata_q <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign err      = err_q;

  // Core is held until each of its outstanding requests has seen its valid
  assign stall = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule
`default_nettype wire
